// File: rtl/pe_mac_vec_if.sv
// Handshake and data bus for the vector multiply-accumulate PE.
// master: producer/consumer side (drives beats and out_ready).
// slave : the PE (drives in_ready, out_valid, out_data, acc_sat).
interface pe_mac_vec_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned A_W   = 8,
    parameter int unsigned B_W   = 8,
    parameter int unsigned OUT_W = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*A_W-1:0]      a_vec;
    logic [LANES*B_W-1:0]      b_vec;
    logic                      in_last;
    logic                      mode_sel;
    logic                      acc_clr;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [OUT_W-1:0]   out_data;
    logic                      acc_sat;

    modport master (
        output in_valid, a_vec, b_vec, in_last, mode_sel, acc_clr, out_ready,
        input  in_ready, out_valid, out_data, acc_sat
    );

    modport slave (
        input  in_valid, a_vec, b_vec, in_last, mode_sel, acc_clr, out_ready,
        output in_ready, out_valid, out_data, acc_sat
    );
endinterface

// File: rtl/pe_mac_vec.sv
// Vector MAC processing element: LANES unsigned x signed products per beat,
// summed into a saturating accumulator; the last beat of a dot product is
// rounded, shifted, optionally ReLU'd and saturated into out_data.
// Ports:
//   clk     - work clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - pe_mac_vec_if.slave: in_valid/in_ready/a_vec/b_vec/in_last/
//             mode_sel/acc_clr in, out_valid/out_ready/out_data/acc_sat out
module pe_mac_vec #(
    parameter int unsigned LANES = 4,
    parameter int unsigned A_W   = 8,
    parameter int unsigned B_W   = 8,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned SHIFT = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    pe_mac_vec_if.slave  bus
);
    localparam int unsigned PW     = A_W + B_W + 1;
    localparam int unsigned SW     = PW + $clog2(LANES);
    localparam int unsigned EW     = ((ACC_W > SW) ? ACC_W : SW) + 1;
    localparam int unsigned RW     = ACC_W + 1;
    localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [EW-1:0] ACC_MAX = {{(EW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EW-1:0] ACC_MIN = {{(EW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [RW-1:0] OUT_MAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [RW-1:0] OUT_MIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [RW-1:0] RND     = (SHIFT > 0) ? (RW'(1) << RND_SH) : RW'(0);

    logic                    w_stall;
    logic                    w_accept;
    logic                    w_s2_fire;
    logic signed [PW-1:0]    w_prod [LANES];
    logic signed [SW-1:0]    w_sum;
    logic signed [EW-1:0]    w_tot;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic                    w_clamp;
    logic signed [RW-1:0]    w_rnd;
    logic signed [RW-1:0]    w_shf;
    logic signed [RW-1:0]    w_relu;
    logic signed [OUT_W-1:0] w_out;

    logic                    r_s1_valid;
    logic                    r_s1_last;
    logic                    r_s1_mode;
    logic signed [PW-1:0]    r_prod [LANES];
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_acc_sat;
    logic                    r_out_valid;
    logic signed [OUT_W-1:0] r_out_data;

    // Whole pipeline freezes while a result waits for the consumer.
    assign w_stall   = r_out_valid & ~bus.out_ready;
    assign w_accept  = bus.in_valid & ~w_stall;
    // A clear discards whatever sits in stage 1 instead of accumulating it.
    assign w_s2_fire = r_s1_valid & ~w_stall & ~bus.acc_clr;

    assign bus.in_ready  = ~w_stall;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.acc_sat   = r_acc_sat;

    // Lane products; activation zero-extended so it multiplies as signed.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_prod[i] = PW'($signed({1'b0, bus.a_vec[i*A_W +: A_W]}))
                      * PW'($signed(bus.b_vec[i*B_W +: B_W]));
        end
    end

    // Adder tree over registered products.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + SW'(r_prod[i]);
        end
    end

    // Saturating accumulate.
    always_comb begin
        w_tot     = EW'(r_acc) + EW'(w_sum);
        w_clamp   = 1'b0;
        w_acc_nxt = w_tot[ACC_W-1:0];
        if (w_tot > ACC_MAX) begin
            w_acc_nxt = ACC_MAX[ACC_W-1:0];
            w_clamp   = 1'b1;
        end else if (w_tot < ACC_MIN) begin
            w_acc_nxt = ACC_MIN[ACC_W-1:0];
            w_clamp   = 1'b1;
        end
    end

    // Round-half-up shift, optional ReLU, then clamp to OUT_W.
    always_comb begin
        w_rnd  = RW'(w_acc_nxt) + RND;
        w_shf  = w_rnd >>> SHIFT;
        w_relu = (r_s1_mode && w_shf[RW-1]) ? '0 : w_shf;
        if (w_relu > OUT_MAX) begin
            w_out = OUT_MAX[OUT_W-1:0];
        end else if (w_relu < OUT_MIN) begin
            w_out = OUT_MIN[OUT_W-1:0];
        end else begin
            w_out = w_relu[OUT_W-1:0];
        end
    end

    // Stage 1: product registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_mode  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_prod[i] <= '0;
            end
        end else if (bus.acc_clr || !w_stall) begin
            r_s1_valid <= w_accept;
            r_s1_last  <= bus.in_last;
            r_s1_mode  <= bus.mode_sel;
            r_prod     <= w_prod;
        end
    end

    // Stage 2: accumulator and sticky saturation flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc     <= '0;
            r_acc_sat <= 1'b0;
        end else if (bus.acc_clr) begin
            r_acc     <= '0;
            r_acc_sat <= 1'b0;
        end else if (w_s2_fire) begin
            if (r_s1_last) begin
                r_acc     <= '0;
                r_acc_sat <= 1'b0;
            end else begin
                r_acc     <= w_acc_nxt;
                r_acc_sat <= r_acc_sat | w_clamp;
            end
        end
    end

    // Output register; a new result may replace one being consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_s2_fire && r_s1_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_out;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule
